// File: rtl/gpio_keypad_scan_if.sv
// Event stream from the keypad scanner to the GPIO register block.
// Carries the FIFO head (valid/code) and the consumer's ready.
interface gpio_keypad_scan_if;
   logic       evt_valid;
   logic       evt_ready;
   logic [7:0] evt_code;

   modport master (output evt_valid, output evt_code, input evt_ready);
   modport slave  (input evt_valid, input evt_code, output evt_ready);
endinterface

// File: rtl/gpio_keypad_scan.sv
// Matrix keypad scanner: column drive, per-key debounce, press/release event FIFO.
// Optional GPIO_KEYPAD_RELEASE_EVT_EN: when defined, release events are queued too.
module gpio_keypad_scan #(
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int SCAN_DIV   = 1000,
   parameter int DEBOUNCE   = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ROWS-1:0]        keypad_row,
   output logic [COLS-1:0]        keypad_col,
   output logic [ROWS*COLS-1:0]   key_state,
   gpio_keypad_scan_if.master     evt,
   output logic                   overflow,
   input  logic                   ovf_clr
);
   localparam int KEYS = ROWS * COLS;
   localparam int DW   = $clog2(SCAN_DIV);
   localparam int CLW  = $clog2(COLS);
   localparam int CW   = $clog2(DEBOUNCE + 1);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int AW1  = AW + 1;

   logic [DW-1:0]  div_reg;
   logic [CLW-1:0] col_reg;
   logic           sample;

   assign sample = (div_reg == DW'(SCAN_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         div_reg <= '0;
         col_reg <= '0;
      end else if (sample) begin
         div_reg <= '0;
         col_reg <= (col_reg == CLW'(COLS - 1)) ? '0 : col_reg + CLW'(1);
      end else begin
         div_reg <= div_reg + DW'(1);
      end
   end

   assign keypad_col = ~(COLS'(1) << col_reg);

   logic [KEYS-1:0] stable_w;
   logic [KEYS-1:0] set_pend;

   // Each key only sees the sample taken while its own column is driven.
   genvar gi;
   generate
      for (gi = 0; gi < KEYS; gi++) begin : g_key
         localparam int R = gi / COLS;
         localparam int C = gi % COLS;
         logic [CW-1:0] cnt_reg;
         logic          stable_reg;
         logic          hit, raw, differ, done;

         assign hit    = sample && (col_reg == CLW'(C));
         assign raw    = ~keypad_row[R];
         assign differ = (raw != stable_reg);
         assign done   = (cnt_reg == CW'(DEBOUNCE - 1));

         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_reg    <= '0;
               stable_reg <= 1'b0;
            end else if (hit) begin
               if (!differ) begin
                  cnt_reg <= '0;
               end else if (done) begin
                  cnt_reg    <= '0;
                  stable_reg <= raw;
               end else begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end
         end

         assign stable_w[gi] = stable_reg;
`ifdef GPIO_KEYPAD_RELEASE_EVT_EN
         assign set_pend[gi] = hit && differ && done;
`else
         assign set_pend[gi] = hit && differ && done && raw;
`endif
      end
   endgenerate

   assign key_state = stable_w;

   logic [KEYS-1:0] pending_reg;
   logic [KEYS-1:0] pend_clr;
   logic            push;
   logic [7:0]      push_code;

   // Descending scan so the lowest pending index is the one left standing.
   always_comb begin
      push      = 1'b0;
      push_code = '0;
      pend_clr  = '0;
      for (int k = KEYS - 1; k >= 0; k--) begin
         if (pending_reg[k]) begin
            push      = 1'b1;
            push_code = {stable_w[k], 7'(k)};
            pend_clr  = KEYS'(1) << k;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) pending_reg <= '0;
      else     pending_reg <= (pending_reg & ~pend_clr) | set_pend;
   end

   logic [7:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]    count_reg;
   logic           overflow_reg;
   logic           valid, full, pop, wr_en, drop;

   assign valid = (count_reg != '0);
   assign full  = (count_reg == AW1'(FIFO_DEPTH));
   assign pop   = valid && evt.evt_ready;
   // A pop in the same cycle frees the slot the push needs.
   assign wr_en = push && (!full || pop);
   assign drop  = push && full && !pop;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_reg] <= push_code;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)   rd_ptr_reg <= rd_ptr_reg + AW'(1);
         count_reg <= count_reg + AW1'(wr_en) - AW1'(pop);
         if (drop)         overflow_reg <= 1'b1;
         else if (ovf_clr) overflow_reg <= 1'b0;
      end
   end

   assign evt.evt_valid = valid;
   assign evt.evt_code  = valid ? mem[rd_ptr_reg] : 8'h00;
   assign overflow      = overflow_reg;
endmodule
